ras_ctrl: RTL and testbench
===========================

RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of stack slots in the attached dual-port BRAM (power of two, >=4).
REQ-002 SHALL have parameter WIDTH, default 36, meaning return-address entry width.
REQ-003 SHALL derive localparams ADDR=$clog2(DEPTH) and CW=$clog2(DEPTH+1).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 push  in  1  call: push push_data.
REQ-008 push_data  in  WIDTH  return address to push.
REQ-009 pop  in  1  return: pop TOS.
REQ-010 restore  in  1  load checkpoint (mispredict recovery).
REQ-011 restore_sp / restore_count / restore_top  in  ADDR / CW / WIDTH  checkpoint values.
REQ-012 top / top_valid  out  WIDTH / 1  current TOS and count!=0.
REQ-013 sp / count  out  ADDR / CW  write pointer and occupancy (checkpoint source).
REQ-014 overflow / underflow  out  1 / 1  one-cycle event pulses.
REQ-015 rea, wea, waddra, wia, raddra  out  BRAM port A (write-only: rea=0, raddra=0).
REQ-016 reb, web, raddrb, waddrb, wib  out  BRAM port B (read-only: web=0, waddrb=0, wib=0); dob in WIDTH, 1-cycle read latency.

Function
REQ-017 TOS SHALL live in register top; BRAM slots sp-1, sp-2, ... (mod DEPTH) SHALL hold entries below TOS, count-1 of them.
REQ-018 Internal next-below value "second" SHALL equal dob when flag sel_dob is set, else register second_q; second_q SHALL capture second every cycle.
REQ-019 Priority per cycle: restore > push&pop > push > pop.
REQ-020 Push, count=0: top<=push_data, count<=1, no BRAM write, sp unchanged.
REQ-021 Push, count>=1: wea=1, waddra=sp, wia=top, same cycle; top<=push_data, second_q<=top, sel_dob<=0, sp<=sp+1 (wraps DEPTH-1->0).
REQ-022 Push at count=DEPTH: count SHALL stay DEPTH, oldest entry overwritten, overflow=1 for one cycle; otherwise count<=count+1.
REQ-023 Pop, count>=2: top<=second, count<=count-1, sp<=sp-1 (wraps 0->DEPTH-1), reb=1, raddrb=sp-2 mod DEPTH, sel_dob<=1.
REQ-024 Pop, count=1: count<=0, top unchanged, no BRAM access, sel_dob<=0.
REQ-025 Pop, count=0: no state change, underflow=1 for one cycle.
REQ-026 Push&pop same cycle, count>=1: top<=push_data only; sp, count, second unchanged, no BRAM access; count=0: treated as push.
REQ-027 Restore: top<=restore_top, sp<=restore_sp, count<=restore_count; if restore_count>=2 then reb=1, raddrb=restore_sp-1, sel_dob<=1, else sel_dob<=0; same-cycle push/pop ignored, no flags.
REQ-028 Back-to-back pops SHALL be accepted every cycle with no stall; second SHALL come from dob of the previous cycle's read.
REQ-029 BRAM port A and B accesses SHALL never target the same address in one cycle.
REQ-030 All outputs except dob-derived muxing SHALL be registered; BRAM strobes combinational from inputs and state.

Reset
REQ-031 On rst: sp=0, count=0, top=0, second_q=0, sel_dob=0, overflow=0, underflow=0, top_valid=0; BRAM contents untouched.
REQ-032 rst asserted mid-operation SHALL abort any in-flight prefetch; first pop after reset SHALL see underflow.

Verification (DEPTH=4, WIDTH=8)
REQ-033 Reset; push 0x11,0x22,0x33 -> top=0x33, count=3, sp=2, BRAM[0]=0x11, BRAM[1]=0x22.
REQ-034 From REQ-033, pop on 3 consecutive cycles -> top 0x22, 0x11, then top_valid=0, count=0; 4th pop -> underflow pulse, count=0.
REQ-035 Push 0x01..0x05 -> overflow pulse on 5th push, count=4, top=0x05; 3 pops -> top 0x04, 0x03, 0x02.
REQ-036 count=2, top=0x22; push 0x44 with pop same cycle -> top=0x44, count=2, sp unchanged, wea=0, reb=0.
REQ-037 Capture sp/count/top at count=3, top=0x33; push 0x55, 0x66; restore captured values -> next cycle top=0x33, count=3; pop -> top=0x22.
REQ-038 Assert rst asynchronously between pops at count=2 -> outputs zero immediately, reb read discarded, next pop -> underflow.

Source files
------------

// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address stack controller, TOS held in a register with the
// entries below it kept in an attached dual-port BRAM (port A write, port B read).
module ras_ctrl #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 36,
   localparam int ADDR = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             restore,
   input  logic [ADDR-1:0]  restore_sp,
   input  logic [CW-1:0]    restore_count,
   input  logic [WIDTH-1:0] restore_top,
   output logic [WIDTH-1:0] top,
   output logic             top_valid,
   output logic [ADDR-1:0]  sp,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow,
   output logic             rea,
   output logic             wea,
   output logic [ADDR-1:0]  waddra,
   output logic [WIDTH-1:0] wia,
   output logic [ADDR-1:0]  raddra,
   output logic             reb,
   output logic             web,
   output logic [ADDR-1:0]  raddrb,
   output logic [ADDR-1:0]  waddrb,
   output logic [WIDTH-1:0] wib,
   input  logic [WIDTH-1:0] dob
);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [WIDTH-1:0] second_q, second;
   logic             sel_dob, empty, many, do_pp, do_push, do_pop;
   assign empty   = count == '0;
   assign many    = count >= CW'(2);
   // push&pop on a non-empty stack only replaces TOS; on an empty one it is a push
   assign do_pp   = !restore && push && pop && !empty;
   assign do_push = !restore && push && !do_pp;
   assign do_pop  = !restore && pop && !push;
   assign second  = sel_dob ? dob : second_q;
   assign top_valid = !empty;
   assign rea    = 1'b0;
   assign raddra = '0;
   assign wea    = do_push && !empty;
   assign waddra = sp;
   assign wia    = top;
   assign web    = 1'b0;
   assign waddrb = '0;
   assign wib    = '0;
   assign reb    = restore ? restore_count >= CW'(2) : do_pop && many;
   assign raddrb = restore ? restore_sp - ADDR'(1) : sp - ADDR'(2);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top       <= '0;
         sp        <= '0;
         count     <= '0;
         second_q  <= '0;
         sel_dob   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         second_q  <= second;
         sel_dob   <= 1'b0;
         overflow  <= do_push && count == FULL;
         underflow <= do_pop && empty;
         if (restore) begin
            top     <= restore_top;
            sp      <= restore_sp;
            count   <= restore_count;
            sel_dob <= restore_count >= CW'(2);
         end else if (do_pp) begin
            top <= push_data;
         end else if (do_push) begin
            top <= push_data;
            if (!empty) begin
               second_q <= top;
               sp       <= sp + ADDR'(1);
            end
            if (count != FULL) count <= count + CW'(1);
         end else if (do_pop && !empty) begin
            count <= count - CW'(1);
            if (many) begin
               top     <= second;
               sp      <= sp - ADDR'(1);
               sel_dob <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed bench for ras_ctrl (DEPTH=4, WIDTH=8) with a queue-based
// stack model compared every cycle and literal checks for the key scenarios.
module tb_ras_ctrl;
   logic       clk = 0, rst = 1;
   logic       push = 0, pop = 0, restore = 0;
   logic [7:0] push_data = 0, restore_top = 0;
   logic [1:0] restore_sp = 0;
   logic [2:0] restore_count = 0;
   logic [7:0] top, wia, wib, dob;
   logic       top_valid, overflow, underflow, rea, wea, reb, web;
   logic [1:0] sp, waddra, raddra, raddrb, waddrb;
   logic [2:0] count;
   logic [7:0] mem [4];
   int         n_chk = 0, n_fail = 0;
   logic [7:0] q[$], saved[$];
   logic [7:0] mtop = 0;
   logic [1:0] msp = 0;
   logic       mof = 0, muf = 0, lw = 0, lr = 0;

   ras_ctrl #(.DEPTH(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
      .restore(restore), .restore_sp(restore_sp), .restore_count(restore_count),
      .restore_top(restore_top), .top(top), .top_valid(top_valid), .sp(sp),
      .count(count), .overflow(overflow), .underflow(underflow), .rea(rea),
      .wea(wea), .waddra(waddra), .wia(wia), .raddra(raddra), .reb(reb),
      .web(web), .raddrb(raddrb), .waddrb(waddrb), .wib(wib), .dob(dob)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (wea) mem[waddra] <= wia;
      if (reb) dob <= mem[raddrb];
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // stack model: q holds TOS last, oldest first
   initial forever begin
      int n;
      @(posedge clk or posedge rst);
      n = q.size();
      if (rst) begin
         q = {}; mtop = 0; msp = 0; mof = 0; muf = 0;
      end else begin
         mof = 0; muf = 0;
         if (restore) begin
            q = saved; mtop = restore_top; msp = restore_sp;
         end else if (push && pop && n > 0) begin
            q[n-1] = push_data; mtop = push_data;
         end else if (push) begin
            if (n == 4) begin void'(q.pop_front()); mof = 1; end
            if (n > 0) msp = msp + 2'd1;
            q.push_back(push_data); mtop = push_data;
         end else if (pop) begin
            if (n == 0) muf = 1;
            else begin
               void'(q.pop_back());
               if (n >= 2) begin mtop = q[$]; msp = msp - 2'd1; end
            end
         end
      end
   end

   initial forever begin
      logic ew, er;
      logic [1:0] ea;
      @(negedge clk);
      ew = !restore && push && !pop && q.size() > 0;
      er = restore ? restore_count >= 2 : (pop && !push && q.size() >= 2);
      ea = restore ? restore_sp - 2'd1 : msp - 2'd2;
      chk("top", top, mtop);
      chk("count", count, q.size());
      chk("sp", sp, msp);
      chk("top_valid", top_valid, q.size() != 0);
      chk("overflow", overflow, mof);
      chk("underflow", underflow, muf);
      chk("wea", wea, ew);
      chk("reb", reb, er);
      chk("port_a_read", {rea, raddra}, 0);
      chk("port_b_write", {web, waddrb, wib}, 0);
      if (ew) begin chk("waddra", waddra, msp); chk("wia", wia, mtop); end
      if (er) chk("raddrb", raddrb, ea);
   end

   task automatic step(input logic pu, input logic po, input logic [7:0] d);
      push = pu; pop = po; push_data = d;
      @(negedge clk);
      lw = wea; lr = reb;
      @(posedge clk); #1;
      push = 0; pop = 0;
   endtask

   task automatic do_restore(input logic [1:0] s, input logic [2:0] c, input logic [7:0] t);
      restore = 1; restore_sp = s; restore_count = c; restore_top = t;
      @(posedge clk); #1;
      restore = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("reset_top", top, 0);
      chk("reset_count", count, 0);
      chk("reset_valid", top_valid, 0);
      // three pushes: BRAM holds the two older entries
      step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
      chk("push3_top", top, 8'h33);
      chk("push3_count", count, 3);
      chk("push3_sp", sp, 2);
      chk("push3_mem0", mem[0], 8'h11);
      chk("push3_mem1", mem[1], 8'h22);
      step(0, 1, 0); chk("pop1_top", top, 8'h22);
      step(0, 1, 0); chk("pop2_top", top, 8'h11);
      step(0, 1, 0); chk("pop3_valid", top_valid, 0); chk("pop3_count", count, 0);
      step(0, 1, 0); chk("pop4_underflow", underflow, 1); chk("pop4_count", count, 0);
      step(0, 0, 0); chk("underflow_pulse", underflow, 0);
      // overflow drops the oldest entry
      do_reset();
      for (int i = 1; i <= 4; i++) step(1, 0, 8'(i));
      chk("push4_overflow", overflow, 0);
      step(1, 0, 8'h05);
      chk("push5_overflow", overflow, 1);
      chk("push5_count", count, 4);
      chk("push5_top", top, 8'h05);
      step(0, 1, 0); chk("ovf_pop1", top, 8'h04); chk("ovf_pulse", overflow, 0);
      step(0, 1, 0); chk("ovf_pop2", top, 8'h03);
      step(0, 1, 0); chk("ovf_pop3", top, 8'h02);
      // simultaneous push and pop replaces TOS only
      do_reset();
      step(1, 0, 8'h11); step(1, 0, 8'h22);
      step(1, 1, 8'h44);
      chk("pp_wea", lw, 0);
      chk("pp_reb", lr, 0);
      chk("pp_top", top, 8'h44);
      chk("pp_count", count, 2);
      chk("pp_sp", sp, 1);
      // checkpoint and restore
      do_reset();
      step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
      saved = q;
      step(1, 0, 8'h55); step(1, 0, 8'h66);
      chk("pre_restore_top", top, 8'h66);
      do_restore(2'd2, 3'd3, 8'h33);
      chk("restore_top", top, 8'h33);
      chk("restore_count", count, 3);
      step(0, 1, 0);
      chk("restore_pop_top", top, 8'h22);
      // async reset aborts an in-flight pop
      pop = 1;
      #2 chk("prefetch_reb", reb, 1);
      rst = 1;
      #1;
      chk("async_top", top, 0);
      chk("async_count", count, 0);
      chk("async_valid", top_valid, 0);
      chk("async_reb", reb, 0);
      pop = 0;
      @(posedge clk); #1;
      rst = 0;
      step(0, 1, 0);
      chk("post_reset_underflow", underflow, 1);
      chk("post_reset_count", count, 0);
      step(0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
